adc_edge_trigger: RTL and testbench

//  Edge trigger for the scope acquisition path. Consumes the 64-bit word of 8 signed
//  8-bit ADC samples after two's-complement conversion and channel remap, and

---
 rtl/adc_edge_trigger_if.sv | 16 +
 rtl/adc_edge_trigger.sv | 228 ++++++++++++++++++++++
 tb/tb_adc_edge_trigger.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_edge_trigger_if.sv
// -----------------------------------------------------------------------------
// adc_edge_trigger_if
// Sample-word stream used on both sides of the edge trigger.
//   valid : the data word is present this cycle (no backpressure)
//   data  : 8 signed 8-bit samples, sample i = data[8i+7:8i], i=0 oldest
// Modports:
//   master : drives valid/data (producer side)
//   slave  : receives valid/data (consumer side)
// -----------------------------------------------------------------------------
interface adc_edge_trigger_if;
    logic        valid;
    logic [63:0] data;

    modport master (output valid, output data);
    modport slave  (input  valid, input  data);
endinterface

// File: rtl/adc_edge_trigger.sv
// -----------------------------------------------------------------------------
// adc_edge_trigger
// Level-crossing trigger with hysteresis for the scope acquisition path. The
// sample stream passes through with two cycles of latency. The output word
// carrying the first qualifying sample is flagged, and that sample's index is
// reported with it.
//
// Ports:
//   axi_aclk     in   clock
//   axi_aresetn  in   asynchronous active-low reset
//   s_if         slave   input sample stream (valid, 64-bit data)
//   m_if         master  output sample stream, s_if delayed by 2 cycles
//   cfg_enable   in   0 forces IDLE and suppresses triggers
//   cfg_arm      in   1-cycle pulse, IDLE -> ARMED
//   cfg_auto     in   re-arm after holdoff (1) or return to IDLE (0)
//   cfg_slope    in   0 rising, 1 falling
//   cfg_level    in   signed trigger level
//   cfg_hyst     in   unsigned hysteresis
//   cfg_holdoff  in   valid words ignored after a trigger
//   m_trig       out  m_if word contains the trigger sample
//   m_trig_pos   out  index of the trigger sample within m_if.data
//   trig_ts      out  word count of the last triggering word
//   armed        out  FSM is in ARMED
// -----------------------------------------------------------------------------
module adc_edge_trigger #(
    parameter int HOLDOFF_W = 16,
    parameter int TS_W      = 32
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    adc_edge_trigger_if.slave    s_if,
    adc_edge_trigger_if.master   m_if,
    input  logic                 cfg_enable,
    input  logic                 cfg_arm,
    input  logic                 cfg_auto,
    input  logic                 cfg_slope,
    input  logic signed [7:0]    cfg_level,
    input  logic [7:0]           cfg_hyst,
    input  logic [HOLDOFF_W-1:0] cfg_holdoff,
    output logic                 m_trig,
    output logic [2:0]           m_trig_pos,
    output logic [TS_W-1:0]      trig_ts,
    output logic                 armed
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HOLDOFF
    } state_t;

    state_t                 r_state;
    state_t                 w_nextState;

    logic signed [9:0]      w_thrSum;
    logic signed [7:0]      w_primeThr;
    logic [7:0]             w_prime;
    logic [7:0]             w_hit;
    logic signed [7:0]      w_samp;

    logic                   r_s1Valid;
    logic [63:0]            r_s1Data;
    logic [7:0]             r_s1Prime;
    logic [7:0]             r_s1Hit;

    logic                   r_primed;
    logic                   w_preRun;
    logic                   w_trigHit;
    logic [2:0]             w_trigPos;
    logic                   w_trig;
    logic                   w_enterArmed;

    logic [HOLDOFF_W-1:0]   r_holdCnt;
    logic [TS_W-1:0]        r_wordCnt;

    logic                   r_mValid;
    logic [63:0]            r_mData;
    logic                   r_mTrig;
    logic [2:0]             r_mTrigPos;
    logic [TS_W-1:0]        r_trigTs;

    // Priming threshold. Level +/- hysteresis needs 10 bits (up to -383 or 382)
    // before being clamped back into the 8-bit sample range.
    always_comb begin
        w_thrSum   = '0;
        w_primeThr = '0;
        if (cfg_slope)
            w_thrSum = {{2{cfg_level[7]}}, cfg_level} + $signed({2'b00, cfg_hyst});
        else
            w_thrSum = {{2{cfg_level[7]}}, cfg_level} - $signed({2'b00, cfg_hyst});
        if (w_thrSum < -10'sd128)
            w_primeThr = -8'sd128;
        else if (w_thrSum > 10'sd127)
            w_primeThr = 8'sd127;
        else
            w_primeThr = w_thrSum[7:0];
    end

    // Per-sample compares: prime means the signal has moved far enough to the
    // far side of the level, hit means it has reached the level.
    always_comb begin
        w_prime = '0;
        w_hit   = '0;
        w_samp  = '0;
        for (int i = 0; i < 8; i++) begin
            w_samp = s_if.data[8*i +: 8];
            if (cfg_slope) begin
                w_prime[i] = (w_samp > w_primeThr);
                w_hit[i]   = (w_samp <= cfg_level);
            end else begin
                w_prime[i] = (w_samp < w_primeThr);
                w_hit[i]   = (w_samp >= cfg_level);
            end
        end
    end

    // Stage 1 holds the word and its compare vectors.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= '0;
            r_s1Prime <= '0;
            r_s1Hit   <= '0;
        end else begin
            r_s1Valid <= s_if.valid;
            r_s1Data  <= s_if.data;
            r_s1Prime <= w_prime;
            r_s1Hit   <= w_hit;
        end
    end

    // Stage 2 trigger search: a hit only counts once a prime has been seen
    // earlier, either in a previous word or in an older sample of this word.
    always_comb begin
        w_trigHit = 1'b0;
        w_trigPos = '0;
        w_preRun  = r_primed;
        for (int i = 0; i < 8; i++) begin
            if (!w_trigHit && w_preRun && r_s1Hit[i]) begin
                w_trigHit = 1'b1;
                w_trigPos = 3'(i);
            end
            w_preRun = w_preRun | r_s1Prime[i];
        end
        w_trig = w_trigHit & r_s1Valid & cfg_enable & (r_state == ST_ARMED);
    end

    // FSM state register.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)
            r_state <= ST_IDLE;
        else
            r_state <= w_nextState;
    end

    // FSM next-state logic. Holdoff only advances on valid words.
    always_comb begin
        w_nextState = r_state;
        if (!cfg_enable) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (cfg_arm) w_nextState = ST_ARMED;
                ST_ARMED:   if (w_trig)  w_nextState = ST_HOLDOFF;
                ST_HOLDOFF: if (r_s1Valid && (r_holdCnt == '0))
                                w_nextState = cfg_auto ? ST_ARMED : ST_IDLE;
                default:    w_nextState = ST_IDLE;
            endcase
        end
        w_enterArmed = (w_nextState == ST_ARMED) && (r_state != ST_ARMED);
    end

    // FSM outputs.
    always_comb begin
        armed = (r_state == ST_ARMED);
    end

    // Holdoff counter: loaded on the trigger, counts down per valid word.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)
            r_holdCnt <= '0;
        else if (!cfg_enable)
            r_holdCnt <= '0;
        else if (w_trig)
            r_holdCnt <= cfg_holdoff;
        else if ((r_state == ST_HOLDOFF) && r_s1Valid && (r_holdCnt != '0))
            r_holdCnt <= r_holdCnt - HOLDOFF_W'(1);
    end

    // Primed flag carries a prime across word boundaries. It starts clean on
    // every arm so a prime seen before arming cannot cause a trigger.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn)
            r_primed <= 1'b0;
        else if (!cfg_enable || w_trig || w_enterArmed)
            r_primed <= 1'b0;
        else if ((r_state == ST_ARMED) && r_s1Valid)
            r_primed <= r_primed | (|r_s1Prime);
    end

    // Stage 2 output registers, word counter and trigger timestamp.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_mValid   <= 1'b0;
            r_mData    <= '0;
            r_mTrig    <= 1'b0;
            r_mTrigPos <= '0;
            r_wordCnt  <= '0;
            r_trigTs   <= '0;
        end else begin
            r_mValid   <= r_s1Valid;
            r_mData    <= r_s1Data;
            r_mTrig    <= w_trig;
            r_mTrigPos <= w_trig ? w_trigPos : 3'd0;
            if (r_s1Valid)
                r_wordCnt <= r_wordCnt + TS_W'(1);
            if (w_trig)
                r_trigTs <= r_wordCnt;
        end
    end

    assign m_if.valid = r_mValid;
    assign m_if.data  = r_mData;
    assign m_trig     = r_mTrig;
    assign m_trig_pos = r_mTrigPos;
    assign trig_ts    = r_trigTs;

endmodule

// File: tb/tb_adc_edge_trigger.sv
// -----------------------------------------------------------------------------
// tb_adc_edge_trigger
// Directed bench for adc_edge_trigger. Each task drives one scenario and
// compares outputs against hand-computed values. A monitor logs every m_trig
// event so scenarios can count triggers and find their word positions.
// -----------------------------------------------------------------------------
module tb_adc_edge_trigger;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cfg_enable = 1'b0;
    logic        cfg_arm = 1'b0;
    logic        cfg_auto = 1'b0;
    logic        cfg_slope = 1'b0;
    logic [7:0]  cfg_level = 8'd0;
    logic [7:0]  cfg_hyst = 8'd0;
    logic [15:0] cfg_holdoff = 16'd0;
    logic        m_trig;
    logic [2:0]  m_trig_pos;
    logic [31:0] trig_ts;
    logic        armed;

    adc_edge_trigger_if s_if ();
    adc_edge_trigger_if m_if ();

    adc_edge_trigger #(.HOLDOFF_W(16), .TS_W(32)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (rst_n),
        .s_if        (s_if),
        .m_if        (m_if),
        .cfg_enable  (cfg_enable),
        .cfg_arm     (cfg_arm),
        .cfg_auto    (cfg_auto),
        .cfg_slope   (cfg_slope),
        .cfg_level   (cfg_level),
        .cfg_hyst    (cfg_hyst),
        .cfg_holdoff (cfg_holdoff),
        .m_trig      (m_trig),
        .m_trig_pos  (m_trig_pos),
        .trig_ts     (trig_ts),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    int          assertCnt = 0;
    int          failCnt = 0;
    int          trigCnt = 0;
    int          lastPos = 0;
    logic [63:0] lastData = '0;
    logic [31:0] lastTs = '0;
    int          mWordIdx = 0;
    int          trigIdx[$];
    int          validSent = 0;

    // Monitor: logs every trigger with its output word index, sampled just
    // after the clock edge.
    always @(posedge clk) begin
        #1;
        if (m_trig) begin
            trigCnt++;
            lastPos  = int'(m_trig_pos);
            lastData = m_if.data;
            lastTs   = trig_ts;
            trigIdx.push_back(m_if.valid ? mWordIdx : -1);
        end
        if (m_if.valid)
            mWordIdx++;
    end

    function automatic logic [63:0] ramp(input int start);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(start + i);
        return w;
    endfunction

    function automatic logic [63:0] fill(input int v);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'(v);
        return w;
    endfunction

    function automatic logic [63:0] setSamp(input logic [63:0] w, input int idx, input int v);
        logic [63:0] r;
        r = w;
        r[8*idx +: 8] = 8'(v);
        return r;
    endfunction

    task automatic step(input logic v, input logic [63:0] d);
        @(negedge clk);
        s_if.valid = v;
        s_if.data  = d;
        if (v) validSent++;
    endtask

    task automatic flush(input int n);
        repeat (n) step(1'b0, 64'h0);
    endtask

    task automatic startTest(input logic slope, input int level, input int hyst,
                             input int holdoff, input logic autoMode);
        @(negedge clk);
        s_if.valid  = 1'b0;
        cfg_enable  = 1'b0;
        cfg_slope   = slope;
        cfg_level   = 8'(level);
        cfg_hyst    = 8'(hyst);
        cfg_holdoff = 16'(holdoff);
        cfg_auto    = autoMode;
        @(negedge clk);
        cfg_enable = 1'b1;
        cfg_arm    = 1'b1;
        @(negedge clk);
        cfg_arm = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = 64'hDEAD_BEEF_0123_4567;
        cfg_enable = 1'b1;
        cfg_arm    = 1'b1;
        repeat (3) @(negedge clk);
        assertCnt++; if (m_if.valid !== 1'b0) begin failCnt++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_if.valid); end
        assertCnt++; if (m_if.data !== 64'h0) begin failCnt++; $display("[TB] FAIL reset_m_data: got %h expected 0", m_if.data); end
        assertCnt++; if (m_trig !== 1'b0) begin failCnt++; $display("[TB] FAIL reset_m_trig: got %b expected 0", m_trig); end
        assertCnt++; if (m_trig_pos !== 3'd0) begin failCnt++; $display("[TB] FAIL reset_m_trig_pos: got %0d expected 0", m_trig_pos); end
        assertCnt++; if (trig_ts !== 32'd0) begin failCnt++; $display("[TB] FAIL reset_trig_ts: got %0d expected 0", trig_ts); end
        assertCnt++; if (armed !== 1'b0) begin failCnt++; $display("[TB] FAIL reset_armed: got %b expected 0", armed); end
        s_if.valid = 1'b0;
        s_if.data  = '0;
        cfg_enable = 1'b0;
        cfg_arm    = 1'b0;
        validSent  = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rising();
        int expTs;
        startTest(1'b0, 0, 4, 0, 1'b0);
        assertCnt++; if (armed !== 1'b1) begin failCnt++; $display("[TB] FAIL rise_armed_after_arm: got %b expected 1", armed); end
        step(1'b1, ramp(-10));
        expTs = validSent;
        step(1'b1, ramp(-2));
        step(1'b0, 64'h0);
        assertCnt++; if (m_if.valid !== 1'b1) begin failCnt++; $display("[TB] FAIL rise_w1_valid: got %b expected 1", m_if.valid); end
        assertCnt++; if (m_if.data !== ramp(-10)) begin failCnt++; $display("[TB] FAIL rise_w1_data: got %h expected %h", m_if.data, ramp(-10)); end
        assertCnt++; if (m_trig !== 1'b0) begin failCnt++; $display("[TB] FAIL rise_w1_trig: got %b expected 0", m_trig); end
        step(1'b0, 64'h0);
        assertCnt++; if (m_if.data !== ramp(-2)) begin failCnt++; $display("[TB] FAIL rise_w2_data: got %h expected %h", m_if.data, ramp(-2)); end
        assertCnt++; if (m_trig !== 1'b1) begin failCnt++; $display("[TB] FAIL rise_w2_trig: got %b expected 1", m_trig); end
        assertCnt++; if (m_trig_pos !== 3'd2) begin failCnt++; $display("[TB] FAIL rise_w2_pos: got %0d expected 2", m_trig_pos); end
        assertCnt++; if (trig_ts !== 32'(expTs)) begin failCnt++; $display("[TB] FAIL rise_trig_ts: got %0d expected %0d", trig_ts, expTs); end
        assertCnt++; if (armed !== 1'b0) begin failCnt++; $display("[TB] FAIL rise_armed_drop: got %b expected 0", armed); end
        step(1'b0, 64'h0);
        assertCnt++; if (m_if.valid !== 1'b0) begin failCnt++; $display("[TB] FAIL rise_idle_valid: got %b expected 0", m_if.valid); end
        flush(2);
    endtask

    task automatic test_no_prime();
        int base;
        startTest(1'b0, 0, 4, 0, 1'b0);
        base = trigCnt;
        step(1'b1, fill(10));
        step(1'b1, ramp(13));
        step(1'b1, fill(-4));
        step(1'b1, ramp(-3));
        flush(4);
        assertCnt++; if (trigCnt !== base) begin failCnt++; $display("[TB] FAIL noprime_trig_count: got %0d expected %0d", trigCnt, base); end
        assertCnt++; if (armed !== 1'b1) begin failCnt++; $display("[TB] FAIL noprime_armed: got %b expected 1", armed); end
    endtask

    task automatic test_falling();
        int base;
        int expTs;
        logic [63:0] w;
        startTest(1'b1, -20, 10, 0, 1'b0);
        w = fill(-15);
        w = setSamp(w, 1, -25);
        w = setSamp(w, 3, 0);
        w = setSamp(w, 6, -20);
        base  = trigCnt;
        expTs = validSent;
        step(1'b1, w);
        flush(4);
        assertCnt++; if (trigCnt !== base + 1) begin failCnt++; $display("[TB] FAIL fall_trig_count: got %0d expected %0d", trigCnt, base + 1); end
        assertCnt++; if (lastPos !== 6) begin failCnt++; $display("[TB] FAIL fall_pos: got %0d expected 6", lastPos); end
        assertCnt++; if (lastData !== w) begin failCnt++; $display("[TB] FAIL fall_data: got %h expected %h", lastData, w); end
        assertCnt++; if (lastTs !== 32'(expTs)) begin failCnt++; $display("[TB] FAIL fall_trig_ts: got %0d expected %0d", lastTs, expTs); end
        assertCnt++; if (armed !== 1'b0) begin failCnt++; $display("[TB] FAIL fall_armed: got %b expected 0", armed); end
    endtask

    task automatic test_auto_holdoff();
        int base;
        int t0;
        int t1;
        startTest(1'b0, 0, 4, 3, 1'b1);
        trigIdx.delete();
        base = mWordIdx;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, (k % 2 == 1) ? fill(50) : fill(-50));
            if (k == 1) flush(4);
        end
        flush(4);
        t0 = (trigIdx.size() > 0) ? trigIdx[0] - base : -1;
        t1 = (trigIdx.size() > 1) ? trigIdx[1] - base : -1;
        assertCnt++; if (trigIdx.size() !== 2) begin failCnt++; $display("[TB] FAIL auto_trig_count: got %0d expected 2", trigIdx.size()); end
        assertCnt++; if (t0 !== 1) begin failCnt++; $display("[TB] FAIL auto_first_idx: got %0d expected 1", t0); end
        assertCnt++; if (t1 !== 7) begin failCnt++; $display("[TB] FAIL auto_second_idx: got %0d expected 7", t1); end
        assertCnt++; if (armed !== 1'b1) begin failCnt++; $display("[TB] FAIL auto_rearmed: got %b expected 1", armed); end
    endtask

    task automatic test_saturation();
        int base;
        startTest(1'b0, -120, 50, 0, 1'b0);
        base = trigCnt;
        step(1'b1, fill(-128));
        step(1'b1, fill(-100));
        flush(4);
        assertCnt++; if (trigCnt !== base) begin failCnt++; $display("[TB] FAIL sat_rise_count: got %0d expected %0d", trigCnt, base); end
        assertCnt++; if (armed !== 1'b1) begin failCnt++; $display("[TB] FAIL sat_rise_armed: got %b expected 1", armed); end
        startTest(1'b1, 120, 50, 0, 1'b0);
        base = trigCnt;
        step(1'b1, fill(127));
        step(1'b1, fill(100));
        flush(4);
        assertCnt++; if (trigCnt !== base) begin failCnt++; $display("[TB] FAIL sat_fall_count: got %0d expected %0d", trigCnt, base); end
        startTest(1'b0, -100, 20, 0, 1'b0);
        base = trigCnt;
        step(1'b1, fill(-121));
        step(1'b1, fill(-100));
        flush(4);
        assertCnt++; if (trigCnt !== base + 1) begin failCnt++; $display("[TB] FAIL near_floor_count: got %0d expected %0d", trigCnt, base + 1); end
        assertCnt++; if (lastPos !== 0) begin failCnt++; $display("[TB] FAIL near_floor_pos: got %0d expected 0", lastPos); end
    endtask

    task automatic test_abort();
        int base;
        int expTs;
        startTest(1'b0, 0, 4, 0, 1'b0);
        base = trigCnt;
        step(1'b1, fill(-50));
        @(negedge clk);
        cfg_enable = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = fill(50);
        validSent++;
        step(1'b0, 64'h0);
        assertCnt++; if (armed !== 1'b0) begin failCnt++; $display("[TB] FAIL abort_armed: got %b expected 0", armed); end
        assertCnt++; if (m_if.valid !== 1'b1) begin failCnt++; $display("[TB] FAIL abort_flow_valid: got %b expected 1", m_if.valid); end
        assertCnt++; if (m_if.data !== fill(-50)) begin failCnt++; $display("[TB] FAIL abort_flow_data: got %h expected %h", m_if.data, fill(-50)); end
        flush(3);
        startTest(1'b0, 0, 4, 0, 1'b0);
        step(1'b1, fill(50));
        flush(4);
        assertCnt++; if (trigCnt !== base) begin failCnt++; $display("[TB] FAIL abort_stale_prime: got %0d expected %0d", trigCnt, base); end

        // Asynchronous reset in the middle of a primed stream.
        startTest(1'b0, 0, 4, 0, 1'b0);
        step(1'b1, fill(-50));
        step(1'b1, fill(-50));
        #2 rst_n = 1'b0;
        #1;
        assertCnt++; if (m_if.valid !== 1'b0) begin failCnt++; $display("[TB] FAIL midreset_valid: got %b expected 0", m_if.valid); end
        assertCnt++; if (m_if.data !== 64'h0) begin failCnt++; $display("[TB] FAIL midreset_data: got %h expected 0", m_if.data); end
        assertCnt++; if (trig_ts !== 32'd0) begin failCnt++; $display("[TB] FAIL midreset_trig_ts: got %0d expected 0", trig_ts); end
        assertCnt++; if (armed !== 1'b0) begin failCnt++; $display("[TB] FAIL midreset_armed: got %b expected 0", armed); end
        s_if.valid = 1'b0;
        validSent  = 0;
        @(negedge clk);
        rst_n = 1'b1;
        base = trigCnt;
        startTest(1'b0, 0, 4, 0, 1'b0);
        step(1'b1, fill(50));
        flush(4);
        assertCnt++; if (trigCnt !== base) begin failCnt++; $display("[TB] FAIL midreset_stale: got %0d expected %0d", trigCnt, base); end
        step(1'b1, fill(-50));
        expTs = validSent;
        step(1'b1, fill(50));
        flush(4);
        assertCnt++; if (trigCnt !== base + 1) begin failCnt++; $display("[TB] FAIL postreset_count: got %0d expected %0d", trigCnt, base + 1); end
        assertCnt++; if (lastTs !== 32'(expTs)) begin failCnt++; $display("[TB] FAIL postreset_ts: got %0d expected %0d", lastTs, expTs); end
    endtask

    initial begin
        s_if.valid = 1'b0;
        s_if.data  = '0;
        test_reset();
        test_rising();
        test_no_prime();
        test_falling();
        test_auto_holdoff();
        test_saturation();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
